ps2_kbd_decoder: RTL and testbench

Parametrised PS/2 keyboard receiver and ASCII translator that sits between the PS/2 pins and the terminal's character consumer. It hardens the serial front end with a synchroniser, glitch filter, parity/stop checking and frame timeout. It adds Ctrl, Caps Lock and VT52 cursor-key sequences. Decoded bytes are queued in an internal FIFO behind a valid/ready handshake.

---
 rtl/ps2_kbd_pkg.sv | 28 ++
 rtl/ps2_kbd_decoder_if.sv | 9 +
 rtl/ps2_scancode_map.sv | 91 +++++++++
 rtl/ps2_kbd_decoder.sv | 240 ++++++++++++++++++++++++
 tb/tb_ps2_kbd_decoder.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/ps2_kbd_pkg.sv
// rtl/ps2_kbd_pkg.sv - scancode/ASCII constants and emitter state for the PS/2 keyboard decoder
package ps2_kbd_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_ESC    = 8'h76;
  localparam logic [7:0] SC_TAB    = 8'h0D;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  localparam logic [7:0] ASCII_ESC   = 8'h1B;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} emit_state_t;

endpackage

// File: rtl/ps2_kbd_decoder_if.sv
// rtl/ps2_kbd_decoder_if.sv - decoded byte stream handshake between decoder and consumer
interface ps2_kbd_decoder_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, valid, input ready);
  modport slave  (input data, valid, output ready);
endinterface

// File: rtl/ps2_scancode_map.sv
// rtl/ps2_scancode_map.sv - combinational set-2 scancode to ASCII/VT52 translator (US layout)
module ps2_scancode_map
  import ps2_kbd_pkg::*;
(
  input  logic [7:0] scancode,
  input  logic       ext,
  input  logic       shift,
  input  logic       ctrl,
  input  logic       caps,
  output logic [1:0] count,
  output logic [7:0] byte1,
  output logic [7:0] byte2
);

  logic [7:0] lo;
  logic [7:0] hi;
  logic       letter;

  // Unshifted/shifted pair per key; lo of zero marks an unmapped code
  always_comb begin
    lo = 8'h00;
    hi = 8'h00;
    case (scancode)
      8'h1C: lo = "a";  8'h32: lo = "b";  8'h21: lo = "c";  8'h23: lo = "d";
      8'h24: lo = "e";  8'h2B: lo = "f";  8'h34: lo = "g";  8'h33: lo = "h";
      8'h43: lo = "i";  8'h3B: lo = "j";  8'h42: lo = "k";  8'h4B: lo = "l";
      8'h3A: lo = "m";  8'h31: lo = "n";  8'h44: lo = "o";  8'h4D: lo = "p";
      8'h15: lo = "q";  8'h2D: lo = "r";  8'h1B: lo = "s";  8'h2C: lo = "t";
      8'h3C: lo = "u";  8'h2A: lo = "v";  8'h1D: lo = "w";  8'h22: lo = "x";
      8'h35: lo = "y";  8'h1A: lo = "z";
      8'h45: {lo, hi} = "0)";
      8'h16: {lo, hi} = "1!";
      8'h1E: {lo, hi} = "2@";
      8'h26: {lo, hi} = "3#";
      8'h25: {lo, hi} = "4$";
      8'h2E: {lo, hi} = "5%";
      8'h36: {lo, hi} = "6^";
      8'h3D: {lo, hi} = "7&";
      8'h3E: {lo, hi} = "8*";
      8'h46: {lo, hi} = "9(";
      8'h0E: {lo, hi} = {8'h60, 8'h7E};
      8'h4E: {lo, hi} = "-_";
      8'h55: {lo, hi} = "=+";
      8'h54: {lo, hi} = "[{";
      8'h5B: {lo, hi} = "]}";
      8'h5D: {lo, hi} = "\\|";
      8'h4C: {lo, hi} = ";:";
      8'h52: {lo, hi} = "'\"";
      8'h41: {lo, hi} = ",<";
      8'h49: {lo, hi} = ".>";
      8'h4A: {lo, hi} = "/?";
      SC_ESC:   {lo, hi} = {ASCII_ESC, ASCII_ESC};
      SC_TAB:   {lo, hi} = {ASCII_TAB, ASCII_TAB};
      SC_BKSP:  {lo, hi} = {ASCII_BS, ASCII_BS};
      SC_ENTER: {lo, hi} = {ASCII_CR, ASCII_CR};
      SC_SPACE: {lo, hi} = {ASCII_SPACE, ASCII_SPACE};
      default: ;
    endcase
  end

  assign letter = (lo >= "a") && (lo <= "z");

  always_comb begin
    count = 2'd0;
    byte1 = 8'h00;
    byte2 = 8'h00;
    if (ext) begin
      case (scancode)
        SC_ENTER: begin count = 2'd1; byte1 = ASCII_CR; end
        SC_UP:    begin count = 2'd2; byte1 = ASCII_ESC; byte2 = "A"; end
        SC_DOWN:  begin count = 2'd2; byte1 = ASCII_ESC; byte2 = "B"; end
        SC_RIGHT: begin count = 2'd2; byte1 = ASCII_ESC; byte2 = "C"; end
        SC_LEFT:  begin count = 2'd2; byte1 = ASCII_ESC; byte2 = "D"; end
        default: ;
      endcase
    end else if (lo != 8'h00) begin
      count = 2'd1;
      if (letter) begin
        if (ctrl)
          byte1 = lo & 8'h1F;
        else if (shift ^ caps)
          byte1 = lo ^ 8'h20;
        else
          byte1 = lo;
      end else begin
        byte1 = shift ? hi : lo;
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// rtl/ps2_kbd_decoder.sv - PS/2 keyboard receiver, modifier tracking, ASCII emitter and output FIFO
module ps2_kbd_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_kbd_decoder_if.master host,
  output logic              caps_lock,
  output logic              frame_err,
  output logic              overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync, data_sync;
  logic          filt_clk, fall;
  logic [FW-1:0] filt_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    sr;
  logic          par, rx_valid;
  logic [TW-1:0] timer;
  logic          ext, brk, lshift, rshift, lctrl, rctrl, caps_held;
  logic [1:0]    tr_cnt;
  logic [7:0]    tr_b1, tr_b2;
  emit_state_t   state, state_next;
  logic [7:0]    b1, b2, push_byte;
  logic          two, load, push, pop, ovf_next, key_event, full, room;
  logic [AW:0]   wptr, rptr, used, free;
  logic [7:0]    mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
        fall     <= filt_clk;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  // Parity is only judged at the stop bit so a bad frame yields exactly one error
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      sr        <= '0;
      par       <= 1'b0;
      timer     <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        timer <= '0;
        if (bit_cnt == 4'd0) begin
          if (data_sync[1]) begin
            frame_err <= 1'b1;
          end else begin
            bit_cnt <= 4'd1;
            par     <= 1'b0;
          end
        end else if (bit_cnt <= 4'd8) begin
          sr      <= {data_sync[1], sr[7:1]};
          par     <= par ^ data_sync[1];
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd9) begin
          par     <= par ^ data_sync[1];
          bit_cnt <= 4'd10;
        end else begin
          bit_cnt <= 4'd0;
          if (data_sync[1] && par)
            rx_valid <= 1'b1;
          else
            frame_err <= 1'b1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt   <= 4'd0;
          timer     <= '0;
          frame_err <= 1'b1;
        end else begin
          timer <= timer + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext       <= 1'b0;
      brk       <= 1'b0;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      lctrl     <= 1'b0;
      rctrl     <= 1'b0;
      caps_held <= 1'b0;
      caps_lock <= 1'b0;
    end else if (rx_valid) begin
      if (sr == SC_EXT) begin
        ext <= 1'b1;
      end else if (sr == SC_BRK) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
        case (sr)
          SC_LSHIFT: lshift <= !brk;
          SC_RSHIFT: rshift <= !brk;
          SC_CTRL: begin
            if (ext) rctrl <= !brk;
            else     lctrl <= !brk;
          end
          SC_CAPS: begin
            if (brk) begin
              caps_held <= 1'b0;
            end else if (!caps_held) begin
              caps_lock <= !caps_lock;
              caps_held <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  ps2_scancode_map u_map (
    .scancode (sr),
    .ext      (ext),
    .shift    (lshift | rshift),
    .ctrl     (lctrl | rctrl),
    .caps     (caps_lock),
    .count    (tr_cnt),
    .byte1    (tr_b1),
    .byte2    (tr_b2)
  );

  assign key_event = rx_valid && !brk && (sr != SC_EXT) && (sr != SC_BRK) && (tr_cnt != 2'd0);
  assign used      = wptr - rptr;
  assign free      = (AW + 1)'(FIFO_DEPTH) - used;
  assign full      = (wptr == {~rptr[AW], rptr[AW-1:0]});
  // Occupancy before any same-cycle pop decides; a whole sequence fits or nothing is queued
  assign room      = (tr_cnt == 2'd2) ? (free >= (AW + 1)'(2)) : !full;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    push       = 1'b0;
    push_byte  = b1;
    ovf_next   = 1'b0;
    case (state)
      IDLE: begin
        if (key_event) begin
          if (room) begin
            load       = 1'b1;
            state_next = EMIT1;
          end else begin
            ovf_next = 1'b1;
          end
        end
      end
      EMIT1: begin
        push       = 1'b1;
        state_next = two ? EMIT2 : IDLE;
      end
      EMIT2: begin
        push       = 1'b1;
        push_byte  = b2;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      overflow <= 1'b0;
      b1       <= '0;
      b2       <= '0;
      two      <= 1'b0;
    end else begin
      state    <= state_next;
      overflow <= ovf_next;
      if (load) begin
        b1  <= tr_b1;
        b2  <= tr_b2;
        two <= (tr_cnt == 2'd2);
      end
    end
  end

  assign pop = host.valid && host.ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW + 1)'(1);
      if (pop)  rptr <= rptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= push_byte;
  end

  assign host.valid = (wptr != rptr);
  assign host.data  = host.valid ? mem[rptr[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// tb/tb_ps2_kbd_decoder.sv - directed scoreboard bench for ps2_kbd_decoder
module tb_ps2_kbd_decoder;
  import ps2_kbd_pkg::*;

  localparam int DEPTH = 4;
  localparam int FLEN  = 4;
  localparam int TMO   = 200;
  localparam int HALF  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic caps_lock, frame_err, overflow;

  ps2_kbd_decoder_if bus();

  ps2_kbd_decoder #(
    .FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .host(bus), .caps_lock(caps_lock), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  int pop_gap = 0;
  int f0, o0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input logic bad_par);
    logic [10:0] fr;
    fr = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      tick(HALF);
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(b, 11, 1'b0);
    tick(HALF);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (frame_err) fe_cnt++;
    if (overflow) ov_cnt++;
    if (!reset && bus.valid && bus.ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pop_data", 32'(bus.data), 32'(mon_exp));
        pop_gap = cyc - last_pop_cyc;
        last_pop_cyc = cyc;
      end
    end
  end

  initial begin
    bus.ready = 1'b0;
    reset = 1'b1;
    tick(5);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_data", 32'(bus.data), 32'h00);
    check("rst_caps", 32'(caps_lock), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    tick(5);

    exp_q.push_back(8'h61);
    send_bits(8'h1C, 10, 1'b0);
    ps2_data = 1'b1;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(FLEN + 4);
    check("lat_valid_early", 32'(bus.valid), 32'd0);
    tick(1);
    check("lat_valid", 32'(bus.valid), 32'd1);
    check("lat_data", 32'(bus.data), 32'h61);
    tick(HALF);
    ps2_clk = 1'b1;
    tick(HALF);
    check("hold_data", 32'(bus.data), 32'h61);
    bus.ready = 1'b1;
    tick(1);
    check("valid_after_pop", 32'(bus.valid), 32'd0);
    check("q_empty_lat", 32'(exp_q.size()), 32'd0);

    exp_q.push_back(8'h41);
    exp_q.push_back(8'h61);
    send(SC_LSHIFT); send(8'h1C); send(SC_BRK); send(8'h1C); send(SC_BRK); send(SC_LSHIFT); send(8'h1C);
    tick(20);
    check("q_empty_shift", 32'(exp_q.size()), 32'd0);

    exp_q.push_back(8'h41);
    send(SC_CAPS); send(SC_CAPS); send(SC_CAPS); send(SC_BRK); send(SC_CAPS); send(8'h1C);
    tick(20);
    check("caps_on", 32'(caps_lock), 32'd1);
    exp_q.push_back(8'h61);
    send(SC_LSHIFT); send(8'h1C); send(SC_BRK); send(SC_LSHIFT);
    tick(20);
    check("q_empty_caps", 32'(exp_q.size()), 32'd0);

    exp_q.push_back(8'h03);
    send(SC_CTRL); send(8'h21); send(SC_BRK); send(SC_CTRL);
    exp_q.push_back(8'h1B);
    exp_q.push_back(8'h41);
    send(SC_EXT); send(SC_UP);
    tick(20);
    check("vt52_gap", 32'(pop_gap), 32'd1);
    send(SC_EXT); send(SC_BRK); send(SC_UP);
    send(8'h05);
    send(SC_CAPS); send(SC_BRK); send(SC_CAPS);
    tick(20);
    check("caps_off", 32'(caps_lock), 32'd0);
    check("q_empty_ctrl", 32'(exp_q.size()), 32'd0);

    f0 = fe_cnt;
    send_bits(8'h1C, 11, 1'b1);
    tick(20);
    check("parity_err", 32'(fe_cnt - f0), 32'd1);
    f0 = fe_cnt;
    send_bits(8'h1C, 5, 1'b0);
    tick(TMO + 20);
    check("timeout_err", 32'(fe_cnt - f0), 32'd1);
    exp_q.push_back(8'h61);
    send(8'h1C);
    tick(20);
    check("after_timeout_no_err", 32'(fe_cnt - f0), 32'd1);
    check("q_empty_err", 32'(exp_q.size()), 32'd0);

    bus.ready = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      exp_q.push_back(8'h61);
      send(8'h1C);
    end
    o0 = ov_cnt;
    send(SC_EXT); send(SC_DOWN);
    tick(10);
    check("overflow_pulse", 32'(ov_cnt - o0), 32'd1);
    exp_q.push_back(8'h61);
    send(8'h1C);
    tick(10);
    check("full_no_overflow", 32'(ov_cnt - o0), 32'd1);
    check("full_valid", 32'(bus.valid), 32'd1);
    check("full_head", 32'(bus.data), 32'h61);
    bus.ready = 1'b1;
    tick(20);
    check("drain_valid", 32'(bus.valid), 32'd0);
    check("q_empty_final", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
